// File: rtl/seven_segment_pkg.sv
// Segment glyph constants shared with the encoder side; bit 6 = segment a down to bit 0 = segment g.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h0D;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_segment_inverse.sv
// Segment pattern to nibble decoder, exact glyph match only.
// Latency: combinational; backpressure: none.
import seven_segment_pkg::*;

module seven_segment_inverse (
  input  logic [6:0] seg,
  output logic       hit,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: hit    = 1'b0;
    endcase
  end

  assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seven_segment_reader.sv
// Recovers per-digit nibbles from a multiplexed seven-segment bus, with frame and error strobes.
// Latency: outputs update STABLE_CYCLES edges after a new bus value is first sampled; backpressure: none.
import seven_segment_pkg::*;

module seven_segment_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [6:0]              s_seg_q, s_seg_d;
  logic [NUM_DIGITS-1:0]   s_an_q, s_an_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  logic                    same;
  logic                    capture;
  logic                    an_onehot;
  logic [IDX_W-1:0]        digit_idx;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic                    glyph_hit;
  logic                    glyph_blank;
  logic [3:0]              glyph_nibble;

  seven_segment_inverse u_inverse (
    .seg    (s_seg_q),
    .hit    (glyph_hit),
    .blank  (glyph_blank),
    .nibble (glyph_nibble)
  );

  assign same      = ({seg_in, an_in} == {s_seg_q, s_an_q});
  assign capture   = same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
  assign an_onehot = (s_an_q != '0) && ((s_an_q & (s_an_q - NUM_DIGITS'(1))) == '0);

  always_comb begin
    digit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_an_q[i]) digit_idx = IDX_W'(i);
    end
  end

  always_comb begin
    s_seg_d       = seg_in;
    s_an_d        = an_in;
    cnt_d         = cnt_q;
    value_d       = value_q;
    digit_valid_d = digit_valid_q;
    seen_d        = seen_q;
    seen_next     = seen_q;
    frame_d       = 1'b0;
    err_d         = 1'b0;

    // Saturation at STABLE_CYCLES is what blocks a second capture of a held value.
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (capture && an_onehot) begin
      seen_next[digit_idx] = 1'b1;
      if (glyph_hit) begin
        value_d[4*digit_idx +: 4]  = glyph_nibble;
        digit_valid_d[digit_idx]   = 1'b1;
      end else begin
        digit_valid_d[digit_idx]   = 1'b0;
        err_d                      = !glyph_blank;
      end
      if (&seen_next) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = seen_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q       <= '0;
      s_an_q        <= '0;
      cnt_q         <= '0;
      value_q       <= '0;
      digit_valid_q <= '0;
      seen_q        <= '0;
      frame_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      s_seg_q       <= s_seg_d;
      s_an_q        <= s_an_d;
      cnt_q         <= cnt_d;
      value_q       <= value_d;
      digit_valid_q <= digit_valid_d;
      seen_q        <= seen_d;
      frame_q       <= frame_d;
      err_q         <= err_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = digit_valid_q;
  assign frame_valid = frame_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with hand-computed expectations.
module tb_seven_segment_reader;

  logic        clk;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;
  int edge_no     = 0;
  int frame_cnt   = 0;
  int err_cnt     = 0;
  int frame_edge  = 0;
  int err_edge    = 0;
  int start_edge  = 0;

  seven_segment_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, observing outputs 1 time unit after each rising edge.
  task automatic cycles(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      edge_no++;
      if (frame_valid) begin
        frame_cnt++;
        frame_edge = edge_no;
      end
      if (err) begin
        err_cnt++;
        err_edge = edge_no;
      end
    end
  endtask

  task automatic clr_pulses();
    frame_cnt = 0;
    err_cnt   = 0;
  endtask

  initial begin
    rst    = 1'b1;
    seg_in = 7'h00;
    an_in  = 4'b0000;

    // 1: reset then idle bus
    cycles(3);
    chk("rst_value", value, 16'h0000);
    chk("rst_dv", digit_valid, 4'h0);
    chk("rst_frame", frame_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    clr_pulses();
    cycles(20);
    chk("idle_value", value, 16'h0000);
    chk("idle_dv", digit_valid, 4'h0);
    chk("idle_frame_cnt", frame_cnt, 0);
    chk("idle_err_cnt", err_cnt, 0);

    // 2: scan "1","2","3","4"
    clr_pulses();
    an_in = 4'b0001; seg_in = 7'h30; cycles(12);
    an_in = 4'b0010; seg_in = 7'h6D; cycles(12);
    an_in = 4'b0100; seg_in = 7'h79; cycles(12);
    chk("scan_no_early_frame", frame_cnt, 0);
    an_in = 4'b1000; seg_in = 7'h33;
    start_edge = edge_no;
    cycles(12);
    chk("scan_value", value, 16'h4321);
    chk("scan_dv", digit_valid, 4'hF);
    chk("scan_frame_cnt", frame_cnt, 1);
    chk("scan_frame_latency", frame_edge - start_edge - 1, 8);
    chk("scan_err_cnt", err_cnt, 0);

    // 3: glitch on digit 0, then "0" held
    clr_pulses();
    an_in = 4'b0001; seg_in = 7'h30; cycles(5);
    seg_in = 7'h7E;
    cycles(8);
    chk("glitch_before_capture", value, 16'h4321);
    cycles(4);
    chk("glitch_value", value, 16'h4320);
    chk("glitch_dv", digit_valid, 4'hF);
    chk("glitch_err_cnt", err_cnt, 0);
    chk("glitch_frame_cnt", frame_cnt, 0);

    // 4: unrecognised pattern on digit 2
    clr_pulses();
    an_in = 4'b0100; seg_in = 7'h01; cycles(12);
    chk("bad_err_cnt", err_cnt, 1);
    chk("bad_dv", digit_valid, 4'hB);
    chk("bad_value", value, 16'h4320);
    chk("bad_frame_cnt", frame_cnt, 0);

    // 5: multi-hot select, then blank on digit 1
    clr_pulses();
    an_in = 4'b0011; seg_in = 7'h30; cycles(20);
    chk("multi_value", value, 16'h4320);
    chk("multi_dv", digit_valid, 4'hB);
    chk("multi_err_cnt", err_cnt, 0);
    an_in = 4'b0010; seg_in = 7'h00; cycles(12);
    chk("blank_dv", digit_valid, 4'h9);
    chk("blank_value", value, 16'h4320);
    chk("blank_err_cnt", err_cnt, 0);
    chk("blank_frame_cnt", frame_cnt, 0);

    // 6: reset mid-window, glyph held through it
    clr_pulses();
    an_in = 4'b1000; seg_in = 7'h4F; cycles(6);
    rst = 1'b1; cycles(1);
    chk("midrst_value", value, 16'h0000);
    chk("midrst_dv", digit_valid, 4'h0);
    rst = 1'b0;
    cycles(8);
    chk("postrst_not_yet", value, 16'h0000);
    cycles(1);
    chk("postrst_value", value, 16'hE000);
    chk("postrst_dv", digit_valid, 4'h8);
    chk("postrst_frame_cnt", frame_cnt, 0);

    // 7: frame completed by a bad glyph: frame and err on the same edge
    clr_pulses();
    an_in = 4'b0001; seg_in = 7'h7B; cycles(12);
    an_in = 4'b0010; seg_in = 7'h00; cycles(12);
    an_in = 4'b0100; seg_in = 7'h12; cycles(12);
    chk("mix_value", value, 16'hE009);
    chk("mix_dv", digit_valid, 4'h9);
    chk("mix_frame_cnt", frame_cnt, 1);
    chk("mix_err_cnt", err_cnt, 1);
    chk("mix_same_edge", frame_edge - err_edge, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
